// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, one-entry output register, redirects,
// and a stop on a delivered ECALL or on a misaligned redirect.
module fetch_controller #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] ECALL_WORD = 32'h00000073,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [63:0]      out_pc,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT,
        ERR
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic        fire;
    logic        load;
    logic        is_ecall;
    logic        aligned;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Combinational fetch address and handshake qualifiers
    always_comb begin
        imem_addr = pc;
        fire      = out_valid & out_ready;
        load      = ~out_valid | out_ready;
        is_ecall  = (imem_instr == ECALL_WORD);
        aligned   = (redirect_pc[1:0] == 2'b00);
    end

    // Fetch FSM with registered outputs and saturating delivery counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (fire && (fetch_count != '1)) begin
                fetch_count <= fetch_count + CNT_ONE;
            end
            case (state)
                RUN, DRAIN: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        if (aligned) begin
                            pc    <= redirect_pc;
                            state <= RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end else if (state == RUN) begin
                        if (load) begin
                            out_instr <= imem_instr;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            if (is_ecall) begin
                                state <= DRAIN;
                            end else begin
                                pc <= pc + 64'd4;
                            end
                        end
                    end else if (fire) begin
                        out_valid <= 1'b0;
                        halted    <= 1'b1;
                        state     <= HALT;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
